// File: rtl/writeback_pkg.sv
// Shared definitions for the rv32i writeback stage: one-hot opcode layout
// and the encodings of the counter write select.
package writeback_pkg;

  // Width of the one-hot opcode_type vector carried down the pipeline.
  localparam int WB_OPCODE_WIDTH = 11;

  // Bit positions inside the one-hot opcode_type vector.
  localparam int OP_LUI    = 0;
  localparam int OP_AUIPC  = 1;
  localparam int OP_JAL    = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_LOAD   = 5;
  localparam int OP_STORE  = 6;
  localparam int OP_ITYPE  = 7;
  localparam int OP_RTYPE  = 8;
  localparam int OP_FENCE  = 9;
  localparam int OP_SYSTEM = 10;

  // Counter write targets selected by cnt_sel.
  localparam logic [1:0] CNT_SEL_MCYCLE_LO   = 2'd0;
  localparam logic [1:0] CNT_SEL_MCYCLE_HI   = 2'd1;
  localparam logic [1:0] CNT_SEL_MINSTRET_LO = 2'd2;
  localparam logic [1:0] CNT_SEL_MINSTRET_HI = 2'd3;

  // Per-counter half write strobes.
  typedef struct packed {
    logic w_lo;
    logic w_hi;
  } cnt_wr_t;

  // Decode a counter write strobe into half-write strobes for one counter.
  // lo_sel/hi_sel are the cnt_sel codes owned by that counter.
  function automatic cnt_wr_t cnt_decode(input logic       w_en,
                                         input logic [1:0] sel,
                                         input logic [1:0] lo_sel,
                                         input logic [1:0] hi_sel);
    cnt_wr_t r;
    r.w_lo = w_en && (sel == lo_sel);
    r.w_hi = w_en && (sel == hi_sel);
    return r;
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Bundle of registered outputs of the memory-access stage feeding writeback.
interface writeback_if
  import writeback_pkg::*;
#(
  parameter int OPCODE_WIDTH = WB_OPCODE_WIDTH
);
  logic                    prev_clk_en;
  logic                    prev_rd_w_en;
  logic [4:0]              prev_rd;
  logic [31:0]             prev_rd_wdata;
  logic [31:0]             prev_data_load;
  logic [OPCODE_WIDTH-1:0] prev_opcode_type;
  logic [31:0]             prev_pc;

  // Memory stage side.
  modport master (
    output prev_clk_en, prev_rd_w_en, prev_rd, prev_rd_wdata,
           prev_data_load, prev_opcode_type, prev_pc
  );

  // Writeback stage side.
  modport slave (
    input  prev_clk_en, prev_rd_w_en, prev_rd, prev_rd_wdata,
           prev_data_load, prev_opcode_type, prev_pc
  );
endinterface

// File: rtl/writeback_csr_counter64.sv
// 64-bit CSR counter built from two 32-bit halves. A low-half write replaces
// the low word and suppresses that cycle's increment; a high-half write
// replaces the high word while the low word still counts, dropping any carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        w_lo,
  input  logic        w_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_next_s;
  logic [31:0] hi_next_s;
  logic [32:0] lo_sum_s;
  logic        lo_inc_s;
  logic        carry_s;

  // Next-state computation for both halves, write taking priority over count.
  always_comb begin
    lo_inc_s  = inc && !inhibit;
    lo_sum_s  = {1'b0, lo_r} + 33'd1;
    carry_s   = 1'b0;
    lo_next_s = lo_r;
    hi_next_s = hi_r;

    if (w_lo) begin
      lo_next_s = wdata;
    end else if (lo_inc_s) begin
      lo_next_s = lo_sum_s[31:0];
      carry_s   = lo_sum_s[32];
    end else begin
      lo_next_s = lo_r;
    end

    if (w_hi) begin
      hi_next_s = wdata;
    end else if (carry_s) begin
      hi_next_s = hi_r + 32'd1;
    end else begin
      hi_next_s = hi_r;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_r <= 32'd0;
      hi_r <= 32'd0;
    end else begin
      lo_r <= lo_next_s;
      hi_r <= hi_next_s;
    end
  end

  assign count = {hi_r, lo_r};

endmodule

// File: rtl/writeback.sv
// rv32i writeback stage: picks load data or the computed result, forwards it
// combinationally, registers the register-file write port and retire strobe,
// and keeps the mcycle/minstret counters.
module writeback
  import writeback_pkg::*;
#(
  parameter int OPCODE_WIDTH = WB_OPCODE_WIDTH
) (
  input  logic        clk,
  input  logic        rstn,
  writeback_if.slave  prev,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        rf_w_en,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  input  logic [1:0]  cnt_inhibit,
  input  logic        cnt_w_en,
  input  logic [1:0]  cnt_sel,
  input  logic [31:0] cnt_wdata,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  localparam logic [OPCODE_WIDTH-1:0] LOAD_MASK =
    {{(OPCODE_WIDTH-1){1'b0}}, 1'b1} << OP_LOAD;

  logic [OPCODE_WIDTH-1:0] opcode_s;
  logic                    is_load_s;
  logic [31:0]             sel_data_s;
  logic                    wr_s;
  logic                    rf_w_en_r;
  logic [4:0]              rf_addr_r;
  logic [31:0]             rf_wdata_r;
  logic                    retire_r;
  logic [31:0]             retire_pc_r;
  cnt_wr_t                 mcycle_wr_s;
  cnt_wr_t                 minstret_wr_s;

  assign opcode_s = prev.prev_opcode_type;

  // Result selection and write qualification; x0 is never written.
  always_comb begin
    is_load_s = |(opcode_s & LOAD_MASK);
    if (is_load_s) begin
      sel_data_s = prev.prev_data_load;
    end else begin
      sel_data_s = prev.prev_rd_wdata;
    end
    wr_s = prev.prev_clk_en && prev.prev_rd_w_en && (prev.prev_rd != 5'd0);
  end

  // Same-cycle forwarding bus for hazard resolution upstream.
  assign fwd_valid = wr_s;
  assign fwd_rd    = prev.prev_rd;
  assign fwd_data  = sel_data_s;

  // Register-file write port; address/data hold while no write is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_w_en_r  <= 1'b0;
      rf_addr_r  <= 5'd0;
      rf_wdata_r <= 32'd0;
    end else begin
      rf_w_en_r <= wr_s;
      if (wr_s) begin
        rf_addr_r  <= prev.prev_rd;
        rf_wdata_r <= sel_data_s;
      end
    end
  end

  // Retirement strobe counts every valid instruction, including x0 targets.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_r    <= 1'b0;
      retire_pc_r <= 32'd0;
    end else begin
      retire_r <= prev.prev_clk_en;
      if (prev.prev_clk_en) begin
        retire_pc_r <= prev.prev_pc;
      end
    end
  end

  assign rf_w_en   = rf_w_en_r;
  assign rf_addr   = rf_addr_r;
  assign rf_wdata  = rf_wdata_r;
  assign retire    = retire_r;
  assign retire_pc = retire_pc_r;

  // Split the single counter write strobe into per-counter half writes.
  always_comb begin
    mcycle_wr_s   = cnt_decode(cnt_w_en, cnt_sel,
                               CNT_SEL_MCYCLE_LO, CNT_SEL_MCYCLE_HI);
    minstret_wr_s = cnt_decode(cnt_w_en, cnt_sel,
                               CNT_SEL_MINSTRET_LO, CNT_SEL_MINSTRET_HI);
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (1'b1),
    .inhibit (cnt_inhibit[0]),
    .w_lo    (mcycle_wr_s.w_lo),
    .w_hi    (mcycle_wr_s.w_hi),
    .wdata   (cnt_wdata),
    .count   (mcycle)
  );

  // minstret counts off the registered retire, one cycle behind it.
  csr_counter64 u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (retire_r),
    .inhibit (cnt_inhibit[1]),
    .w_lo    (minstret_wr_s.w_lo),
    .w_hi    (minstret_wr_s.w_hi),
    .wdata   (cnt_wdata),
    .count   (minstret)
  );

endmodule

// File: tb/tb_writeback.sv
// Directed testbench for the writeback stage.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk;
  logic        rstn;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        rf_w_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic [31:0] retire_pc;
  logic [1:0]  cnt_inhibit;
  logic        cnt_w_en;
  logic [1:0]  cnt_sel;
  logic [31:0] cnt_wdata;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  int pass_cnt;
  int total_cnt;

  logic [WB_OPCODE_WIDTH-1:0] op_load;
  logic [WB_OPCODE_WIDTH-1:0] op_alu;
  logic [WB_OPCODE_WIDTH-1:0] op_store;
  logic [63:0] mc0;
  logic [63:0] mi0;

  writeback_if #(.OPCODE_WIDTH(WB_OPCODE_WIDTH)) prev_bus ();

  writeback #(.OPCODE_WIDTH(WB_OPCODE_WIDTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .prev        (prev_bus),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .rf_w_en     (rf_w_en),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
    .retire      (retire),
    .retire_pc   (retire_pc),
    .cnt_inhibit (cnt_inhibit),
    .cnt_w_en    (cnt_w_en),
    .cnt_sel     (cnt_sel),
    .cnt_wdata   (cnt_wdata),
    .mcycle      (mcycle),
    .minstret    (minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wen, input logic [4:0] rd,
                       input logic [WB_OPCODE_WIDTH-1:0] op,
                       input logic [31:0] wdata, input logic [31:0] ld,
                       input logic [31:0] pc);
    prev_bus.prev_clk_en      = en;
    prev_bus.prev_rd_w_en     = wen;
    prev_bus.prev_rd          = rd;
    prev_bus.prev_opcode_type = op;
    prev_bus.prev_rd_wdata    = wdata;
    prev_bus.prev_data_load   = ld;
    prev_bus.prev_pc          = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, op_alu, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cnt_inhibit = 2'b00; cnt_w_en = 1'b0; cnt_sel = 2'd0; cnt_wdata = 32'd0;
    bubble();
    #2;
    total_cnt++; if (rf_w_en !== 1'b0) $display("FAIL reset_rf_w_en: got %b exp 0", rf_w_en); else pass_cnt++;
    total_cnt++; if (rf_addr !== 5'd0) $display("FAIL reset_rf_addr: got %0d exp 0", rf_addr); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'd0) $display("FAIL reset_rf_wdata: got %h exp 0", rf_wdata); else pass_cnt++;
    total_cnt++; if (retire !== 1'b0 || retire_pc !== 32'd0) $display("FAIL reset_retire: got %b/%h exp 0/0", retire, retire_pc); else pass_cnt++;
    #12;
    total_cnt++; if (mcycle !== 64'd0 || minstret !== 64'd0) $display("FAIL reset_counters: got %h/%h exp 0/0", mcycle, minstret); else pass_cnt++;
    total_cnt++; if (fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid: got %b exp 0", fwd_valid); else pass_cnt++;
    #6; // t=20, a falling edge
    rstn = 1'b1;
    step();
    total_cnt++; if (mcycle !== 64'd1) $display("FAIL first_mcycle: got %h exp 1", mcycle); else pass_cnt++;
  endtask

  task automatic test_load_retire();
    drive(1'b1, 1'b1, 5'd5, op_load, 32'h0000_1234, 32'hFFFF_FF80, 32'h0000_0100);
    mi0 = minstret;
    #1;
    total_cnt++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5) $display("FAIL load_fwd_ctl: got %b/%0d exp 1/5", fwd_valid, fwd_rd); else pass_cnt++;
    total_cnt++; if (fwd_data !== 32'hFFFF_FF80) $display("FAIL load_fwd_data: got %h exp ffffff80", fwd_data); else pass_cnt++;
    step();
    total_cnt++; if (rf_w_en !== 1'b1 || rf_addr !== 5'd5) $display("FAIL load_rf_ctl: got %b/%0d exp 1/5", rf_w_en, rf_addr); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'hFFFF_FF80) $display("FAIL load_rf_wdata: got %h exp ffffff80", rf_wdata); else pass_cnt++;
    total_cnt++; if (retire !== 1'b1 || retire_pc !== 32'h100) $display("FAIL load_retire: got %b/%h exp 1/00000100", retire, retire_pc); else pass_cnt++;
    total_cnt++; if (minstret !== mi0) $display("FAIL load_minstret_early: got %h exp %h", minstret, mi0); else pass_cnt++;
    bubble();
    step();
    total_cnt++; if (minstret !== mi0 + 64'd1) $display("FAIL load_minstret: got %h exp %h", minstret, mi0 + 64'd1); else pass_cnt++;
    total_cnt++; if (rf_w_en !== 1'b0 || rf_addr !== 5'd5 || rf_wdata !== 32'hFFFF_FF80) $display("FAIL load_hold: got %b/%0d/%h exp 0/5/ffffff80", rf_w_en, rf_addr, rf_wdata); else pass_cnt++;
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, op_alu, 32'h0000_DEAD, 32'h1111_1111, 32'h0000_0104);
    mi0 = minstret;
    #1;
    total_cnt++; if (fwd_valid !== 1'b0) $display("FAIL x0_fwd_valid: got %b exp 0", fwd_valid); else pass_cnt++;
    total_cnt++; if (fwd_data !== 32'h0000_DEAD) $display("FAIL alu_fwd_data: got %h exp 0000dead", fwd_data); else pass_cnt++;
    step();
    total_cnt++; if (rf_w_en !== 1'b0) $display("FAIL x0_rf_w_en: got %b exp 0", rf_w_en); else pass_cnt++;
    total_cnt++; if (retire !== 1'b1 || retire_pc !== 32'h104) $display("FAIL x0_retire: got %b/%h exp 1/00000104", retire, retire_pc); else pass_cnt++;
    bubble();
    step();
    total_cnt++; if (minstret !== mi0 + 64'd1) $display("FAIL x0_minstret: got %h exp %h", minstret, mi0 + 64'd1); else pass_cnt++;
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b1, 5'd7, op_alu, 32'h0000_0077, 32'd0, 32'h0000_0300);
    mc0 = mcycle;
    mi0 = minstret;
    #1;
    total_cnt++; if (fwd_valid !== 1'b0) $display("FAIL bubble_fwd_valid: got %b exp 0", fwd_valid); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (retire !== 1'b0 || rf_w_en !== 1'b0) $display("FAIL bubble_idle: got %b/%b exp 0/0", retire, rf_w_en); else pass_cnt++;
    end
    total_cnt++; if (mcycle !== mc0 + 64'd3) $display("FAIL bubble_mcycle: got %h exp %h", mcycle, mc0 + 64'd3); else pass_cnt++;
    total_cnt++; if (minstret !== mi0) $display("FAIL bubble_minstret: got %h exp %h", minstret, mi0); else pass_cnt++;
    total_cnt++; if (retire_pc !== 32'h104) $display("FAIL bubble_retire_pc_hold: got %h exp 00000104", retire_pc); else pass_cnt++;
  endtask

  task automatic test_carry_inhibit();
    cnt_w_en = 1'b1; cnt_sel = CNT_SEL_MCYCLE_LO; cnt_wdata = 32'hFFFF_FFFF;
    step();
    total_cnt++; if (mcycle !== 64'h0000_0000_FFFF_FFFF) $display("FAIL mcycle_lo_write: got %h exp 00000000ffffffff", mcycle); else pass_cnt++;
    cnt_w_en = 1'b0;
    step();
    total_cnt++; if (mcycle !== 64'h0000_0001_0000_0000) $display("FAIL mcycle_carry: got %h exp 0000000100000000", mcycle); else pass_cnt++;
    // Wrap of the full 64-bit counter.
    cnt_w_en = 1'b1; cnt_sel = CNT_SEL_MCYCLE_HI; cnt_wdata = 32'hFFFF_FFFF;
    step();
    cnt_sel = CNT_SEL_MCYCLE_LO;
    step();
    total_cnt++; if (mcycle !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mcycle_all_ones: got %h exp ffffffffffffffff", mcycle); else pass_cnt++;
    cnt_w_en = 1'b0;
    step();
    total_cnt++; if (mcycle !== 64'd0) $display("FAIL mcycle_wrap: got %h exp 0", mcycle); else pass_cnt++;
    // Inhibit both counters while instructions keep retiring.
    cnt_inhibit = 2'b11;
    drive(1'b1, 1'b0, 5'd0, op_store, 32'd0, 32'd0, 32'h0000_0400);
    mc0 = mcycle;
    mi0 = minstret;
    for (int i = 0; i < 4; i++) step();
    total_cnt++; if (mcycle !== mc0 || minstret !== mi0) $display("FAIL inhibit_frozen: got %h/%h exp %h/%h", mcycle, minstret, mc0, mi0); else pass_cnt++;
    cnt_inhibit = 2'b00;
    bubble();
    step();
    total_cnt++; if (minstret !== mi0 + 64'd1) $display("FAIL inhibit_release: got %h exp %h", minstret, mi0 + 64'd1); else pass_cnt++;
  endtask

  task automatic test_high_collision();
    cnt_w_en = 1'b1; cnt_sel = CNT_SEL_MINSTRET_HI; cnt_wdata = 32'd0;
    step();
    cnt_sel = CNT_SEL_MINSTRET_LO; cnt_wdata = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 5'd0, op_store, 32'd0, 32'd0, 32'h0000_0500);
    step();
    total_cnt++; if (minstret !== 64'h0000_0000_FFFF_FFFF || retire !== 1'b1) $display("FAIL hi_setup: got %h/%b exp 00000000ffffffff/1", minstret, retire); else pass_cnt++;
    cnt_sel = CNT_SEL_MINSTRET_HI; cnt_wdata = 32'h0000_0007;
    bubble();
    mc0 = mcycle;
    step();
    total_cnt++; if (minstret !== 64'h0000_0007_0000_0000) $display("FAIL hi_collision: got %h exp 0000000700000000", minstret); else pass_cnt++;
    total_cnt++; if (mcycle !== mc0 + 64'd1) $display("FAIL hi_other_counter: got %h exp %h", mcycle, mc0 + 64'd1); else pass_cnt++;
    cnt_w_en = 1'b0;
    step();
    total_cnt++; if (minstret !== 64'h0000_0007_0000_0000) $display("FAIL hi_settle: got %h exp 0000000700000000", minstret); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3];
    logic [31:0] dat [3];
    logic [31:0] lds [3];
    logic [31:0] exp_d [3];
    logic [WB_OPCODE_WIDTH-1:0] ops [3];
    rds = '{5'd1, 5'd31, 5'd12};
    dat = '{32'hAAAA_0001, 32'h5555_0002, 32'h0BAD_F00D};
    lds = '{32'h0000_0010, 32'h0000_007F, 32'hFFFF_8000};
    ops = '{op_alu, op_load, op_alu};
    exp_d = '{32'hAAAA_0001, 32'h0000_007F, 32'h0BAD_F00D};
    mi0 = minstret;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, rds[i], ops[i], dat[i], lds[i], 32'h0000_0600 + 32'(i) * 32'd4);
      step();
      total_cnt++; if (rf_w_en !== 1'b1 || rf_addr !== rds[i] || rf_wdata !== exp_d[i]) $display("FAIL b2b_write%0d: got %b/%0d/%h exp 1/%0d/%h", i, rf_w_en, rf_addr, rf_wdata, rds[i], exp_d[i]); else pass_cnt++;
      total_cnt++; if (retire !== 1'b1 || retire_pc !== 32'h0000_0600 + 32'(i) * 32'd4) $display("FAIL b2b_retire%0d: got %b/%h exp 1/%h", i, retire, retire_pc, 32'h0000_0600 + 32'(i) * 32'd4); else pass_cnt++;
    end
    bubble();
    step();
    total_cnt++; if (minstret !== mi0 + 64'd3) $display("FAIL b2b_minstret: got %h exp %h", minstret, mi0 + 64'd3); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 5'd9, op_alu, 32'h0000_0055, 32'd0, 32'h0000_0700);
    step();
    total_cnt++; if (rf_w_en !== 1'b1 || mcycle === 64'd0 || minstret === 64'd0) $display("FAIL arst_precond: got %b/%h/%h exp 1/nonzero/nonzero", rf_w_en, mcycle, minstret); else pass_cnt++;
    #2;
    rstn = 1'b0;
    #1;
    total_cnt++; if (rf_w_en !== 1'b0 || rf_addr !== 5'd0 || rf_wdata !== 32'd0) $display("FAIL arst_rf: got %b/%0d/%h exp 0/0/0", rf_w_en, rf_addr, rf_wdata); else pass_cnt++;
    total_cnt++; if (retire !== 1'b0 || retire_pc !== 32'd0) $display("FAIL arst_retire: got %b/%h exp 0/0", retire, retire_pc); else pass_cnt++;
    total_cnt++; if (mcycle !== 64'd0 || minstret !== 64'd0) $display("FAIL arst_counters: got %h/%h exp 0/0", mcycle, minstret); else pass_cnt++;
    bubble();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step();
    drive(1'b1, 1'b1, 5'd3, op_alu, 32'h0000_0ABC, 32'd0, 32'h0000_0200);
    step();
    total_cnt++; if (rf_w_en !== 1'b1 || rf_addr !== 5'd3 || rf_wdata !== 32'h0000_0ABC) $display("FAIL arst_after_write: got %b/%0d/%h exp 1/3/00000abc", rf_w_en, rf_addr, rf_wdata); else pass_cnt++;
    total_cnt++; if (retire !== 1'b1 || retire_pc !== 32'h200) $display("FAIL arst_after_retire: got %b/%h exp 1/00000200", retire, retire_pc); else pass_cnt++;
    bubble();
    step();
    total_cnt++; if (minstret !== 64'd1) $display("FAIL arst_after_minstret: got %h exp 1", minstret); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    op_load  = 11'd1 << OP_LOAD;
    op_alu   = 11'd1 << OP_RTYPE;
    op_store = 11'd1 << OP_STORE;
    test_reset();
    test_load_retire();
    test_x0();
    test_bubble();
    test_carry_inhibit();
    test_high_collision();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
